a51_session_ctrl: RTL
=====================

# a51_session_ctrl

Session controller for the A5/1 keystream core. It latches a 64-bit session key and 22-bit frame number and serially loads them into the core. It then waits for the core's warm-up to finish and collects one 228-bit GSM keystream block (two 114-bit bursts). The block is packed MSB-first into bytes and delivered through a small FIFO with valid/ready handshake. It sits between the cipher configuration logic and the burst XOR datapath, and owns the core's reset, `startloading` and `keybit` pins.

## Interface
- `FIFO_DEPTH`, 4, keystream byte FIFO entries; power of 2, ≥2.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  session request; accepted when `start & !busy`.
- `key`  in  64  session key, sampled on accept.
- `fn`  in  22  frame number, sampled on accept.
- `cont`  in  1  continuous-session request (used only with the macro enabled).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the 228th bit has been sampled.
- `overrun`  out  1  sticky; a completed byte was dropped because the FIFO was full.
- `timeout`  out  1  sticky; `core_doneloading` was not seen within 255 cycles of entering WAITRUN.
- `ks_data`  out  8  FIFO head byte.
- `ks_valid`  out  1  FIFO non-empty.
- `ks_ready`  in  1  consumer accepts the byte when `ks_valid & ks_ready`.
- `ks_last`  out  1  head byte is the final byte of a block.
- `ks_nbits`  out  4  valid bits in the head byte: 8, or 4 on the last byte.
- `core_rst_n`  out  1  active-low reset to the core.
- `core_startloading`  out  1  load strobe to the core.
- `core_keybit`  out  1  serial key/frame bit to the core.
- `core_bitout`  in  1  keystream bit from the core.
- `core_doneloading`  in  1  core-running indication.

## Operation
- **Reset values:** all outputs 0, except `core_rst_n`=0 while `rst` is high and 1 otherwise. `ks_nbits` resets to 0. The FIFO is emptied, and the FSM enters IDLE.
- **IDLE:** on accept, latch `key`/`fn`, clear `overrun` and `timeout`, then go to START.
- **START** (1 cycle): `core_startloading`=1. Go to KEY.
- **KEY** (64 cycles): `core_keybit`=`key[i]`, i=0..63, LSB first. Go to FRAME.
- **FRAME** (22 cycles): `core_keybit`=`fn[j]`, j=0..21, LSB first. Go to WAITRUN.
- **WAITRUN:** `core_keybit`=0. Go to COLLECT in the first cycle `core_doneloading`=1; that cycle's `core_bitout` is bit 0. On the 256th cycle without `core_doneloading`, set `timeout` and go to FLUSH.
- **COLLECT:** sample `core_bitout` on each of 228 cycles, bit 0 included. Shift bits into the byte register MSB-first. Every 8th bit pushes a byte. Bits 224..227 go into `ks_data[7:4]` with `[3:0]`=0, pushed with last=1 and nbits=4. `done` pulses on the cycle bit 227 is sampled. Go to FLUSH.
- **FLUSH** (1 cycle): `core_rst_n`=0, returning the core to its idle state. Then go to IDLE, or to START per Configuration.
- **FIFO:** a push and a pop in the same cycle are both honoured. A push when the FIFO is full (after any same-cycle pop) drops the byte and sets `overrun`. The session continues and never stalls, because the core has no enable.
- **Busy:** `start` while `busy` is ignored. Bytes from a finished session keep draining while a new session loads.
- **Mid-session reset:** `rst` abandons the session immediately. The FIFO is cleared, and the core is held in reset for the duration of `rst`.

## Timing
- Accept edge T. `core_startloading` is high in cycle T+1. Key bit i is driven in cycle T+2+i. Frame bit j is driven in cycle T+66+j.
- With the A5/1 core, `core_doneloading` is first high in cycle T+1+189. The first byte is pushed at T+197 and is visible on `ks_valid` the following cycle.
- Bytes are produced every 8 cycles, 29 bytes per block. One block takes 190+228+1 cycles from accept to IDLE.
- All outputs are registered except `ks_*`, which are the combinational FIFO head.

## Configuration
- **`A51_SESSION_CTRL_FN_AUTOINC_EN` defined:** if `cont`=1 during FLUSH, the controller increments the latched `fn` by 1 modulo 2^22 (0x3FFFFF→0x000000) and goes directly to START, keeping the same key. `overrun`/`timeout` are not cleared. If `cont`=0, it goes to IDLE.
- **Not defined:** `cont` is ignored, and FLUSH always goes to IDLE.

## Test plan
- **Reset:** reset with `rst`=1 for 3 cycles → all outputs 0, `core_rst_n`=0, then 1 after release, `busy`=0.
- **Single session:** `key`=0x1223456789ABCDEF, `fn`=0x134 against the A5/1 core with `ks_ready`=1 → 29 bytes matching the golden 228-bit vector. Last byte has `ks_nbits`=4, low nibble 0, `ks_last`=1. `done` pulses once. `overrun`=0.
- **Load sequencing:** `core_keybit` equals `key[i]` in cycles T+2..T+65 and `fn[j]` in cycles T+66..T+87. `core_startloading` is high only in cycle T+1.
- **Backpressure:** `ks_ready`=0 for the whole block with `FIFO_DEPTH`=4 → first 4 bytes retained in order, `overrun`=1. `start` is then accepted again and clears `overrun`.
- **Timeout:** stub core with `core_doneloading` tied 0 → `timeout`=1 at WAITRUN+256, one FLUSH cycle, `busy`=0.
- **Auto-increment (macro defined):** `cont`=1, `fn`=0x3FFFFF → second session loads `fn`=0 with no idle cycle, and its keystream matches golden(`key`, 0).

Source files
------------

// File: rtl/a51_session_ctrl.sv
// A5/1 session controller: loads key/frame serially into the core, collects one 228-bit
// keystream block and streams it out as bytes through a small FIFO. Optional: A51_SESSION_CTRL_FN_AUTOINC_EN.
module a51_session_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key,
  input  logic [21:0] fn,
  input  logic        cont,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic        timeout,
  output logic [7:0]  ks_data,
  output logic        ks_valid,
  input  logic        ks_ready,
  output logic        ks_last,
  output logic [3:0]  ks_nbits,
  output logic        core_rst_n,
  output logic        core_startloading,
  output logic        core_keybit,
  input  logic        core_bitout,
  input  logic        core_doneloading
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_KEY, S_FRAME, S_WAITRUN, S_COLLECT, S_FLUSH
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [3:0] nbits;
  } ks_beat_t;

  state_t      state;
  logic [63:0] key_r;
  logic [21:0] fn_r;
  logic [7:0]  cnt;
  logic [6:0]  byte_sr;
  logic        accept;

  ks_beat_t    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic        push, pop, full_eff, wr;
  ks_beat_t    push_beat, head;

  assign accept = start & ~busy;

`ifndef A51_SESSION_CTRL_FN_AUTOINC_EN
  logic unused_cont;
  assign unused_cont = cont;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      timeout           <= 1'b0;
      core_rst_n        <= 1'b0;
      core_startloading <= 1'b0;
      core_keybit       <= 1'b0;
      cnt               <= '0;
      key_r             <= '0;
      fn_r              <= '0;
      byte_sr           <= '0;
    end else begin
      done              <= 1'b0;
      core_rst_n        <= 1'b1;
      core_startloading <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          key_r             <= key;
          fn_r              <= fn;
          timeout           <= 1'b0;
          busy              <= 1'b1;
          core_startloading <= 1'b1;
          state             <= S_START;
        end
        S_START: begin
          core_keybit <= key_r[0];
          cnt         <= '0;
          state       <= S_KEY;
        end
        // cnt indexes the bit currently on core_keybit; the next one is staged each edge
        S_KEY: if (cnt == 8'd63) begin
          core_keybit <= fn_r[0];
          cnt         <= '0;
          state       <= S_FRAME;
        end else begin
          core_keybit <= key_r[cnt[5:0] + 6'd1];
          cnt         <= cnt + 8'd1;
        end
        S_FRAME: if (cnt == 8'd21) begin
          core_keybit <= 1'b0;
          cnt         <= '0;
          state       <= S_WAITRUN;
        end else begin
          core_keybit <= fn_r[cnt[4:0] + 5'd1];
          cnt         <= cnt + 8'd1;
        end
        // the cycle doneloading rises already carries keystream bit 0
        S_WAITRUN: if (core_doneloading) begin
          byte_sr <= {byte_sr[5:0], core_bitout};
          cnt     <= 8'd1;
          state   <= S_COLLECT;
        end else if (cnt == 8'd255) begin
          timeout    <= 1'b1;
          core_rst_n <= 1'b0;
          state      <= S_FLUSH;
        end else begin
          cnt <= cnt + 8'd1;
        end
        S_COLLECT: begin
          byte_sr <= {byte_sr[5:0], core_bitout};
          if (cnt == 8'd227) begin
            done       <= 1'b1;
            core_rst_n <= 1'b0;
            state      <= S_FLUSH;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_FLUSH: begin
`ifdef A51_SESSION_CTRL_FN_AUTOINC_EN
          if (cont) begin
            fn_r              <= fn_r + 22'd1;
            core_startloading <= 1'b1;
            state             <= S_START;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
`else
          busy  <= 1'b0;
          state <= S_IDLE;
`endif
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // byte assembly taps the live core bit so the push lands on the 8th-bit edge
  always_comb begin
    push      = 1'b0;
    push_beat = '0;
    if (state == S_COLLECT) begin
      if (cnt == 8'd227) begin
        push            = 1'b1;
        push_beat.data  = {byte_sr[2:0], core_bitout, 4'b0000};
        push_beat.last  = 1'b1;
        push_beat.nbits = 4'd4;
      end else if (cnt[2:0] == 3'd7) begin
        push            = 1'b1;
        push_beat.data  = {byte_sr, core_bitout};
        push_beat.nbits = 4'd8;
      end
    end
  end

  assign ks_valid = (count != '0);
  assign pop      = ks_valid & ks_ready;
  assign full_eff = (count == (AW+1)'(FIFO_DEPTH)) & ~pop;
  assign wr       = push & ~full_eff;
  assign head     = mem[rd_ptr];
  assign ks_data  = ks_valid ? head.data  : '0;
  assign ks_last  = ks_valid ? head.last  : 1'b0;
  assign ks_nbits = ks_valid ? head.nbits : '0;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= push_beat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
      if (accept)              overrun <= 1'b0;
      else if (push & full_eff) overrun <= 1'b1;
    end
  end
endmodule
